// File: rtl/conv_result_writer_if.sv
// Valid/ready write port from the conv result writer to the output feature-map buffer.
// The master drives beat address/data/valid; the slave returns ready.
interface conv_result_writer_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 72
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (
    output addr,
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  addr,
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/conv_result_writer.sv
// Conv result drain: buffers un-throttled result words, splits them into write beats with
// row/column address generation. Define CONV_WB_RELU_EN to clamp negative channels to zero.
module conv_result_writer #(
  parameter int unsigned CONV_OUT_NUM   = 18,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MEM_DATA_WIDTH = 72,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DIM_WIDTH      = 9,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [CONV_OUT_NUM*DATA_WIDTH-1:0]  res_data_in,
  input  logic                                res_valid_in,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0]               cfg_row_stride,
  input  logic [DIM_WIDTH-1:0]                cfg_cols,
  input  logic [DIM_WIDTH-1:0]                cfg_rows,
  conv_result_writer_if.master                mem_wr,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                overflow
);

  localparam int unsigned WordWidth = CONV_OUT_NUM * DATA_WIDTH;
  localparam int unsigned Beats     = WordWidth / MEM_DATA_WIDTH;
  localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW      = PtrW + 2;
  localparam int unsigned EntryW    = ADDR_WIDTH + WordWidth;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  stride_q;
  logic [DIM_WIDTH-1:0]   cols_q, rows_q;
  logic [DIM_WIDTH-1:0]   in_col_q, in_row_q;
  logic [ADDR_WIDTH-1:0]  in_row_start_q, in_pix_addr_q;

  logic [EntryW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]        count_q, count_d;
  logic                   full_q, full_d;

  logic [WordWidth-1:0]   out_word_q;
  logic [ADDR_WIDTH-1:0]  out_addr_q;
  logic [BeatW-1:0]       beat_q;
  logic                   out_valid_q, out_valid_d;
  logic                   overflow_q, frame_done_q;

  logic                   start_acc, push_evt, push_ok, pop, hs, last_beat, fifo_empty;
  logic                   last_col, last_pixel;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [WordWidth-1:0]   rd_word, relu_word;

  assign start_acc  = (state_q == StIdle) && start;
  assign push_evt   = (state_q == StRun) && res_valid_in;
  assign push_ok    = push_evt && !full_q;
  assign fifo_empty = (count_q == '0);
  assign hs         = out_valid_q && mem_wr.ready;
  assign last_beat  = (beat_q == BeatW'(Beats - 1));
  assign pop        = !fifo_empty && (!out_valid_q || (hs && last_beat));
  assign last_col   = (in_col_q == cols_q - DIM_WIDTH'(1));
  assign last_pixel = last_col && (in_row_q == rows_q - DIM_WIDTH'(1));

  assign {rd_addr, rd_word} = fifo_mem[rd_ptr_q];

`ifdef CONV_WB_RELU_EN
  always_comb begin
    relu_word = rd_word;
    for (int unsigned i = 0; i < CONV_OUT_NUM; i++) begin
      if (rd_word[i*DATA_WIDTH+DATA_WIDTH-1]) begin
        relu_word[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end
`else
  assign relu_word = rd_word;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (cfg_cols == '0 || cfg_rows == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (push_evt && last_pixel) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty && (!out_valid_q || (hs && last_beat))) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Occupancy counts the word held in the output register, so FIFO_DEPTH words are
  // absorbed in total before the full flag drops input.
  always_comb begin
    count_d = count_q + OccW'(push_ok) - OccW'(pop);
    out_valid_d = out_valid_q;
    if (pop) begin
      out_valid_d = 1'b1;
    end else if (hs && last_beat) begin
      out_valid_d = 1'b0;
    end
    full_d = ((count_d + OccW'(out_valid_d)) >= OccW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= {in_pix_addr_q, res_data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= StIdle;
      stride_q       <= '0;
      cols_q         <= '0;
      rows_q         <= '0;
      in_col_q       <= '0;
      in_row_q       <= '0;
      in_row_start_q <= '0;
      in_pix_addr_q  <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      out_word_q     <= '0;
      out_addr_q     <= '0;
      beat_q         <= '0;
      out_valid_q    <= 1'b0;
      overflow_q     <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        stride_q       <= cfg_row_stride;
        cols_q         <= cfg_cols;
        rows_q         <= cfg_rows;
        in_col_q       <= '0;
        in_row_q       <= '0;
        in_row_start_q <= cfg_base_addr;
        in_pix_addr_q  <= cfg_base_addr;
        overflow_q     <= 1'b0;
      end else if (push_evt) begin
        // Dropped words still advance the pixel position, leaving a hole in the map.
        if (full_q) overflow_q <= 1'b1;
        if (last_col) begin
          in_col_q       <= '0;
          in_row_q       <= in_row_q + DIM_WIDTH'(1);
          in_row_start_q <= in_row_start_q + stride_q;
          in_pix_addr_q  <= in_row_start_q + stride_q;
        end else begin
          in_col_q      <= in_col_q + DIM_WIDTH'(1);
          in_pix_addr_q <= in_pix_addr_q + ADDR_WIDTH'(Beats);
        end
      end
      wr_ptr_q    <= wr_ptr_q + PtrW'(push_ok);
      rd_ptr_q    <= rd_ptr_q + PtrW'(pop);
      count_q     <= count_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      if (pop) begin
        out_word_q <= relu_word;
        out_addr_q <= rd_addr;
        beat_q     <= '0;
      end else if (hs && !last_beat) begin
        out_addr_q <= out_addr_q + ADDR_WIDTH'(1);
        beat_q     <= beat_q + BeatW'(1);
      end
      frame_done_q <= (state_q == StDone);
    end
  end

  always_comb begin
    mem_wr.data = '0;
    for (int unsigned b = 0; b < Beats; b++) begin
      if (beat_q == BeatW'(b)) mem_wr.data = out_word_q[b*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    end
  end

  assign mem_wr.addr  = out_addr_q;
  assign mem_wr.valid = out_valid_q;
  assign busy         = (state_q == StRun) || (state_q == StDrain);
  assign frame_done   = frame_done_q;
  assign overflow     = overflow_q;

endmodule
